// File: rtl/regfile_mp.sv
// Multi-read-port register file with main, link and overflow-flag write paths,
// optional write-to-read bypass, and a sequential zero-scrub after reset or on
// request. While the scrub runs, ready is low, writes are ignored and all read
// ports return zero.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned LINK_REG = 31,
   parameter int unsigned FLAG_REG = 30,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr_req,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       link_en,
   input  logic [DATA_W-1:0]          link_data,
   input  logic                       ovf,
   input  logic                       addr_err,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic                       ready,
   output logic                       ovf_flag
);

   localparam int unsigned       NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_REG);
   localparam logic [ADDR_W-1:0] FLAG_A   = ADDR_W'(FLAG_REG);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                ovf_flag_q, ovf_flag_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic                active;
   logic                main_commit;
   logic                link_commit;
   logic                flag_commit;
   logic [NUM_REGS-1:0] hit;
   logic [DATA_W-1:0]   wval [NUM_REGS];
   logic [ADDR_W-1:0]   rd_a [NUM_RD];

   assign active      = (state_q == READY);
   assign main_commit = active & wr_en & ~ovf & ~addr_err & (wr_addr != '0);
   assign link_commit = active & link_en;
   assign flag_commit = active & ovf;
   assign ready       = active;
   assign ovf_flag    = ovf_flag_q;

   // Per-register write resolution: flag beats main beats link; register 0 never written.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         hit[i]  = 1'b0;
         wval[i] = '0;
         if (i != 0) begin
            if (flag_commit && (FLAG_A == ADDR_W'(i))) begin
               hit[i]  = 1'b1;
               wval[i] = DATA_W'(1);
            end else if (main_commit && (wr_addr == ADDR_W'(i))) begin
               hit[i]  = 1'b1;
               wval[i] = wr_data;
            end else if (link_commit && (LINK_A == ADDR_W'(i))) begin
               hit[i]  = 1'b1;
               wval[i] = link_data;
            end
         end
      end
   end

   // Next-state logic for the scrub/ready controller and the registered flag bit.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ovf_flag_d = ovf_flag_q;
      case (state_q)
         CLEAR: begin
            ovf_flag_d = 1'b0;
            ptr_d      = ptr_q + 1'b1;
            if (ptr_q == '1) begin
               state_d = READY;
               ptr_d   = '0;
            end
         end
         READY: begin
            if (clr_req) begin
               state_d    = CLEAR;
               ptr_d      = '0;
               ovf_flag_d = 1'b0;
            end else if (hit[FLAG_A]) begin
               ovf_flag_d = wval[FLAG_A][0];
            end else begin
               ovf_flag_d = regs_q[FLAG_A][0];
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   // Controller state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= CLEAR;
         ptr_q      <= '0;
         ovf_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ovf_flag_q <= ovf_flag_d;
      end
   end

   // Storage: scrub zeroes one register per cycle; otherwise commit resolved writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if ((state_q == CLEAR) && (ptr_q == ADDR_W'(i))) begin
               regs_q[i] <= '0;
            end else if (hit[i]) begin
               regs_q[i] <= wval[i];
            end
         end
      end
   end

   // Combinational read ports; zero while scrubbing or when addressing register 0.
   always_comb begin
      rd_data = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_a[k] = rd_addr[k*ADDR_W +: ADDR_W];
         if (active && (rd_a[k] != '0)) begin
            if ((BYPASS != 0) && hit[rd_a[k]]) begin
               rd_data[k*DATA_W +: DATA_W] = wval[rd_a[k]];
            end else begin
               rd_data[k*DATA_W +: DATA_W] = regs_q[rd_a[k]];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes the expected outputs of each
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_regfile_mp;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_RD   = 3;
   localparam int NREGS    = 32;
   localparam int LINK_REG = 31;
   localparam int FLAG_REG = 30;
   localparam int BYPASS   = 1;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      clr_req;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_data;
   logic                      link_en;
   logic [DATA_W-1:0]         link_data;
   logic                      ovf;
   logic                      addr_err;
   logic [NUM_RD*ADDR_W-1:0]  rd_addr;
   logic [NUM_RD*DATA_W-1:0]  rd_data;
   logic                      ready;
   logic                      ovf_flag;

   regfile_mp #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_RD  (NUM_RD),
      .LINK_REG(LINK_REG),
      .FLAG_REG(FLAG_REG),
      .BYPASS  (BYPASS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (clr_req),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .link_en  (link_en),
      .link_data(link_data),
      .ovf      (ovf),
      .addr_err (addr_err),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .ready    (ready),
      .ovf_flag (ovf_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                     rdy;
      logic                     flg;
      logic [NUM_RD*DATA_W-1:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: architectural contents plus a countdown of scrub cycles.
   logic [DATA_W-1:0] mem [NREGS];
   bit                known = 0;
   int                scrub_left = 0;

   function automatic bit m_ready();
      return known && (scrub_left == 0);
   endfunction

   // Value register a holds after the coming edge when the file is ready.
   function automatic logic [DATA_W-1:0] next_val(int a);
      logic [DATA_W-1:0] v;
      v = mem[a];
      if (link_en && a == LINK_REG) v = link_data;
      if (wr_en && !ovf && !addr_err && wr_addr != 0 && a == int'(wr_addr)) v = wr_data;
      if (ovf && a == FLAG_REG) v = 1;
      return v;
   endfunction

   task automatic push_expect();
      exp_t e;
      int   a;
      if (!known) return;
      e.rdy = m_ready();
      e.flg = m_ready() ? mem[FLAG_REG][0] : 1'b0;
      e.rd  = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
         if (m_ready() && a != 0)
            e.rd[k*DATA_W +: DATA_W] = (BYPASS != 0) ? next_val(a) : mem[a];
      end
      q.push_back(e);
   endtask

   task automatic model_edge();
      logic [DATA_W-1:0] nm [NREGS];
      if (!reset) begin
         known      = 1;
         scrub_left = NREGS;
      end else if (!known) begin
         // contents unknown until the first reset
      end else if (scrub_left == 0) begin
         for (int a = 0; a < NREGS; a++) nm[a] = next_val(a);
         for (int a = 0; a < NREGS; a++) mem[a] = nm[a];
         if (clr_req) scrub_left = NREGS;
      end else begin
         scrub_left--;
         if (scrub_left == 0)
            for (int a = 0; a < NREGS; a++) mem[a] = '0;
      end
   endtask

   task automatic step();
      push_expect();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      reset = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      link_en = 1'b0; link_data = '0; ovf = 1'b0; addr_err = 1'b0;
   endtask

   task automatic set_rd(int k, int a);
      rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endtask

   // Monitor: outputs are valid every cycle once the expectation exists.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (ready !== e.rdy) begin
            errors++;
            $display("FAIL ready t=%0t got %b expected %b", $time, ready, e.rdy);
         end
         checks++;
         if (ovf_flag !== e.flg) begin
            errors++;
            $display("FAIL ovf_flag t=%0t got %b expected %b", $time, ovf_flag, e.flg);
         end
         for (int k = 0; k < NUM_RD; k++) begin
            checks++;
            if (rd_data[k*DATA_W +: DATA_W] !== e.rd[k*DATA_W +: DATA_W]) begin
               errors++;
               $display("FAIL rd_port%0d t=%0t addr %0d got %h expected %h", k, $time,
                        rd_addr[k*ADDR_W +: ADDR_W], rd_data[k*DATA_W +: DATA_W],
                        e.rd[k*DATA_W +: DATA_W]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rd_addr = '0;
      reset   = 1'b0;
      step();
      reset = 1'b1;
      // Initial scrub, reads scattered across the file.
      for (int c = 0; c < 34; c++) begin
         for (int k = 0; k < NUM_RD; k++) set_rd(k, $urandom_range(0, NREGS-1));
         step();
      end
      // Every register reads zero.
      for (int a = 0; a < NREGS; a++) begin
         set_rd(0, a); set_rd(1, (a + 1) % NREGS); set_rd(2, NREGS - 1 - a);
         step();
      end
      // Plain write with same-cycle read.
      wr_en = 1; wr_addr = 8; wr_data = 32'hDEADBEEF; set_rd(0, 8); set_rd(1, 8); step();
      idle(); step();
      // Writes to register 0 dropped.
      wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; set_rd(0, 0); step();
      idle(); step();
      // Overflow suppresses main write and sets the flag register.
      wr_en = 1; wr_addr = 9; wr_data = 32'h7FFFFFFF; ovf = 1; set_rd(0, 9); set_rd(1, 30); step();
      idle(); step(); step();
      // Address error suppresses main write only.
      wr_en = 1; wr_addr = 9; wr_data = 32'h7FFFFFFF; addr_err = 1; step();
      idle(); step();
      // Main write beats link write on the link register.
      wr_en = 1; wr_addr = 31; wr_data = 32'hAAAA0000; link_en = 1; link_data = 32'h00400008;
      set_rd(0, 31); step();
      idle(); step();
      link_en = 1; link_data = 32'h00400008; step();
      idle(); step();
      // Main write to the flag register clears flag bit 0.
      wr_en = 1; wr_addr = 30; wr_data = 32'h0000_0002; set_rd(1, 30); step();
      idle(); step();
      // Write together with clr_req: write commits, then a full scrub.
      wr_en = 1; wr_addr = 5; wr_data = 32'h55; clr_req = 1; set_rd(0, 5); step();
      idle();
      for (int c = 0; c < 10; c++) begin
         wr_en = 1; wr_addr = 5; wr_data = $urandom; clr_req = $urandom_range(0, 1);
         step();
      end
      // Reset mid-scrub restarts from pointer 0.
      idle(); reset = 1'b0; wr_en = 1; wr_addr = 5; wr_data = 32'h99; step();
      idle();
      for (int c = 0; c < 34; c++) step();
      // Randomised traffic.
      for (int c = 0; c < 800; c++) begin
         reset     = ($urandom_range(0, 399) != 0);
         clr_req   = ($urandom_range(0, 99) == 0);
         wr_en     = ($urandom_range(0, 3) != 0);
         wr_addr   = ADDR_W'($urandom_range(0, NREGS-1));
         wr_data   = $urandom;
         link_en   = ($urandom_range(0, 3) == 0);
         link_data = $urandom;
         ovf       = ($urandom_range(0, 7) == 0);
         addr_err  = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < NUM_RD; k++) begin
            case ($urandom_range(0, 3))
               0: set_rd(k, int'(wr_addr));
               1: set_rd(k, ($urandom_range(0, 1) != 0) ? LINK_REG : FLAG_REG);
               default: set_rd(k, $urandom_range(0, NREGS-1));
            endcase
         end
         step();
      end
      idle();
      step();
      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
